// File: rtl/shape_det_pkg.sv
// ---------------------------------------------------------------------------
// shape_det_pkg
//
// Shared types and constants for the shape pattern detector.
//   - det_state_e : frame-tracking states (HUNT plus the four expected runs)
//   - DEF_*       : default run-length expectations for the L/H/L/H frame
//   - ERR_W/ERR_MAX : error counter width and its saturation value
//   - err_inc()   : saturating increment for the error counter
// ---------------------------------------------------------------------------
package shape_det_pkg;

    // HUNT waits for a 1->0 transition; R0..R3 track the low/high/low/high
    // runs of one frame in order.
    typedef enum logic [2:0] {
        HUNT = 3'd0,
        R0   = 3'd1,
        R1   = 3'd2,
        R2   = 3'd3,
        R3   = 3'd4
    } det_state_e;

    localparam int DEF_RUNW = 4;
    localparam int DEF_L0   = 4;
    localparam int DEF_H1   = 2;
    localparam int DEF_L2   = 1;
    localparam int DEF_H3   = 4;

    localparam int                ERR_W   = 8;
    localparam logic [ERR_W-1:0]  ERR_MAX = 8'd255;

    // Error counter increment that sticks at ERR_MAX instead of wrapping.
    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt);
        logic [ERR_W-1:0] result;
        if (cnt == ERR_MAX) begin
            result = cnt;
        end else begin
            result = cnt + ERR_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/sck_edge_sync.sv
// ---------------------------------------------------------------------------
// sck_edge_sync
//
// Brings the producer's sck/shape pair into the clk domain and flags the
// mid-bit sampling point (falling edge of the synchronised sck).
//
// Ports:
//   clk       in  : system clock
//   rst       in  : synchronous active-high reset
//   enable    in  : qualifies the sample event (synchronisers always run)
//   sck_in    in  : asynchronous bit clock from the producer
//   shape_in  in  : asynchronous serial waveform from the producer
//   sample_ev out : one-cycle pulse on a synchronised sck falling edge
//   shape_s   out : synchronised shape, valid to sample when sample_ev is high
// ---------------------------------------------------------------------------
module sck_edge_sync
    import shape_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic sck_in,
    input  logic shape_in,
    output logic sample_ev,
    output logic shape_s
);

    logic sck_meta_q,   sck_meta_d;
    logic sck_sync_q,   sck_sync_d;
    logic sck_prev_q,   sck_prev_d;
    logic shape_meta_q, shape_meta_d;
    logic shape_sync_q, shape_sync_d;

    // Two-flop chains for both inputs, plus one extra sck stage so the edge
    // detector compares two already-stable samples. These keep running while
    // enable is low so that re-enabling never sees a stale edge.
    always_comb begin
        sck_meta_d   = sck_in;
        sck_sync_d   = sck_meta_q;
        sck_prev_d   = sck_sync_q;
        shape_meta_d = shape_in;
        shape_sync_d = shape_meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_meta_q   <= 1'b0;
            sck_sync_q   <= 1'b0;
            sck_prev_q   <= 1'b0;
            shape_meta_q <= 1'b0;
            shape_sync_q <= 1'b0;
        end else begin
            sck_meta_q   <= sck_meta_d;
            sck_sync_q   <= sck_sync_d;
            sck_prev_q   <= sck_prev_d;
            shape_meta_q <= shape_meta_d;
            shape_sync_q <= shape_sync_d;
        end
    end

    // Sampling on the falling edge keeps us half a bit away from the
    // producer's launch edge, so shape has long settled through its own
    // synchroniser by the time we look at it.
    assign sample_ev = ~sck_sync_q & sck_prev_q & enable;
    assign shape_s   = shape_sync_q;

endmodule

// File: rtl/shape_pattern_detector.sv
// ---------------------------------------------------------------------------
// shape_pattern_detector
//
// Samples the producer's serial waveform once per sck period and checks the
// run lengths of equal samples against an L0/H1/L2/H3 (low/high/low/high)
// frame. Reports a match pulse per good frame, a lock flag and a saturating
// frame-error count.
//
// Ports:
//   clk      in           : system clock
//   rst      in           : synchronous active-high reset
//   enable   in           : when low, sample events are ignored, state held
//   sck_in   in           : producer bit clock (asynchronous)
//   shape_in in           : producer serial waveform (changes on sck rise)
//   match    out          : one-cycle pulse per verified frame
//   locked   out          : set by a match, cleared by any error
//   err_cnt  out [ERR_W]  : frame error count, saturates at ERR_MAX
//   run_len  out [RUNW]   : current run length (debug)
// ---------------------------------------------------------------------------
module shape_pattern_detector
    import shape_det_pkg::*;
#(
    parameter int RUNW = DEF_RUNW,
    parameter int L0   = DEF_L0,
    parameter int H1   = DEF_H1,
    parameter int L2   = DEF_L2,
    parameter int H3   = DEF_H3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sck_in,
    input  logic             shape_in,
    output logic             match,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt,
    output logic [RUNW-1:0]  run_len
);

    localparam logic [RUNW-1:0] RUN_MAX = '1;
    localparam logic [RUNW-1:0] RUN_ONE = RUNW'(1);
    localparam logic [RUNW-1:0] L0_RUN  = RUNW'(L0);
    localparam logic [RUNW-1:0] H1_RUN  = RUNW'(H1);
    localparam logic [RUNW-1:0] L2_RUN  = RUNW'(L2);
    localparam logic [RUNW-1:0] H3_RUN  = RUNW'(H3);

    logic sample_ev;
    logic shape_s;

    det_state_e       state_q,    state_d;
    logic [RUNW-1:0]  run_q,      run_d;
    logic             last_bit_q, last_bit_d;
    logic             match_q,    match_d;
    logic             locked_q,   locked_d;
    logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;
    logic             frame_err;

    sck_edge_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sck_in    (sck_in),
        .shape_in  (shape_in),
        .sample_ev (sample_ev),
        .shape_s   (shape_s)
    );

    // Frame checker. Everything except match holds its value between sample
    // events, which is also how enable gating works: sample_ev already
    // carries enable. Within a run state the current run's polarity is known
    // from the state itself, so "same bit" and "transition" are decided from
    // shape_s directly; last_bit only matters in HUNT, where we need to see a
    // genuine 1->0 edge before trusting a new low run.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        last_bit_d = last_bit_q;
        match_d    = 1'b0;
        locked_d   = locked_q;
        err_cnt_d  = err_cnt_q;
        frame_err  = 1'b0;

        if (sample_ev) begin
            last_bit_d = shape_s;

            unique case (state_q)
                HUNT: begin
                    if (!shape_s && last_bit_q) begin
                        state_d = R0;
                        run_d   = RUN_ONE;
                    end else begin
                        run_d   = '0;
                    end
                end

                R0: begin
                    if (!shape_s) begin
                        if (run_q == RUN_MAX) frame_err = 1'b1;
                        else                  run_d     = run_q + RUN_ONE;
                    end else if (run_q == L0_RUN) begin
                        state_d = R1;
                        run_d   = RUN_ONE;
                    end else begin
                        frame_err = 1'b1;
                    end
                end

                R1: begin
                    if (shape_s) begin
                        if (run_q == RUN_MAX) frame_err = 1'b1;
                        else                  run_d     = run_q + RUN_ONE;
                    end else if (run_q == H1_RUN) begin
                        state_d = R2;
                        run_d   = RUN_ONE;
                    end else begin
                        frame_err = 1'b1;
                    end
                end

                R2: begin
                    if (!shape_s) begin
                        if (run_q == RUN_MAX) frame_err = 1'b1;
                        else                  run_d     = run_q + RUN_ONE;
                    end else if (run_q == L2_RUN) begin
                        state_d = R3;
                        run_d   = RUN_ONE;
                    end else begin
                        frame_err = 1'b1;
                    end
                end

                R3: begin
                    if (shape_s) begin
                        if (run_q == RUN_MAX) frame_err = 1'b1;
                        else                  run_d     = run_q + RUN_ONE;
                    end else if (run_q == H3_RUN) begin
                        // The 1->0 edge that closes this frame is also the
                        // first sample of the next frame's opening low run.
                        match_d  = 1'b1;
                        locked_d = 1'b1;
                        state_d  = R0;
                        run_d    = RUN_ONE;
                    end else begin
                        frame_err = 1'b1;
                    end
                end

                default: begin
                    state_d = HUNT;
                    run_d   = '0;
                end
            endcase

            // A single error takes us to HUNT, and HUNT never raises errors,
            // so each bad frame bumps the counter exactly once.
            if (frame_err) begin
                state_d   = HUNT;
                run_d     = '0;
                locked_d  = 1'b0;
                err_cnt_d = err_inc(err_cnt_q);
            end
        end
    end

    // State and output registers. last_bit resets high so that a stream
    // starting low right after reset is taken as a 1->0 edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            run_q      <= '0;
            last_bit_q <= 1'b1;
            match_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            last_bit_q <= last_bit_d;
            match_q    <= match_d;
            locked_q   <= locked_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign match   = match_q;
    assign locked  = locked_q;
    assign err_cnt = err_cnt_q;
    assign run_len = run_q;

endmodule

// File: tb/tb_shape_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_shape_pattern_detector
//
// Directed bench for shape_pattern_detector: clean frames, a bad H1 frame
// with relock, enable gating in R3, reset mid-frame, run-length saturation
// and error counter saturation. Expected values are worked out by hand from
// the frame rules.
// ---------------------------------------------------------------------------
module tb_shape_pattern_detector;
    import shape_det_pkg::*;

    localparam int HALF       = 16;
    localparam int SCK_PERIOD = 2 * HALF;
    localparam int FRAME_BITS = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sck_in;
    logic       shape_in;
    logic       match;
    logic       locked;
    logic [7:0] err_cnt;
    logic [3:0] run_len;

    int vectorCount = 0;
    int failCount   = 0;
    int cycleCnt    = 0;
    int matchCount  = 0;
    int longMatch   = 0;
    int matchTimes[$];
    logic matchPrev = 1'b0;
    int gap1;
    int gap2;

    shape_pattern_detector dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sck_in   (sck_in),
        .shape_in (shape_in),
        .match    (match),
        .locked   (locked),
        .err_cnt  (err_cnt),
        .run_len  (run_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // Watch match between edges: count pulses, note when they happen and
    // flag any pulse that lasts longer than one cycle.
    always @(negedge clk) begin
        if (match) begin
            matchCount++;
            matchTimes.push_back(cycleCnt);
            if (matchPrev) longMatch++;
        end
        matchPrev = match;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One producer bit: shape launched with the sck rising edge, held for a
    // full period; the detector samples it on the falling edge.
    task automatic applyStimulus(input logic b);
        sck_in   = 1'b1;
        shape_in = b;
        repeat (HALF) @(negedge clk);
        sck_in   = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic sendRun(input logic b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(b);
    endtask

    task automatic sendFrame(input int l0, input int h1, input int l2, input int h3);
        sendRun(1'b0, l0);
        sendRun(1'b1, h1);
        sendRun(1'b0, l2);
        sendRun(1'b1, h3);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        sck_in   = 1'b0;
        shape_in = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_match",   match,   0);
        checkOutput("rst_locked",  locked,  0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_run_len", run_len, 0);
        checkOutput("rst_state",   32'(dut.state_q), 32'(HUNT));
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] clean frames");
        sendRun(1'b0, 4);
        checkOutput("clean_l0_run", run_len, 4);
        sendRun(1'b1, 2);
        sendRun(1'b0, 1);
        sendRun(1'b1, 4);
        checkOutput("clean_no_early_match", matchCount, 0);
        applyStimulus(1'b0);
        checkOutput("clean_first_match", matchCount, 1);
        checkOutput("clean_locked_first", locked, 1);
        sendFrame(3, 2, 1, 4);
        applyStimulus(1'b0);
        sendFrame(3, 2, 1, 4);
        applyStimulus(1'b0);
        checkOutput("clean_match_count", matchCount, 3);
        gap1 = 0;
        gap2 = 0;
        if (matchTimes.size() >= 3) begin
            gap1 = matchTimes[1] - matchTimes[0];
            gap2 = matchTimes[2] - matchTimes[1];
        end
        checkOutput("clean_gap1", gap1, FRAME_BITS * SCK_PERIOD);
        checkOutput("clean_gap2", gap2, FRAME_BITS * SCK_PERIOD);
        checkOutput("clean_locked",  locked,  1);
        checkOutput("clean_err_cnt", err_cnt, 0);
        checkOutput("clean_run_len", run_len, 1);
        checkOutput("clean_state",   32'(dut.state_q), 32'(R0));

        $display("[TB] bad H1 frame");
        sendFrame(3, 3, 1, 4);
        checkOutput("badh1_err_cnt",  err_cnt, 1);
        checkOutput("badh1_locked",   locked,  0);
        checkOutput("badh1_no_match", matchCount, 3);
        checkOutput("badh1_state",    32'(dut.state_q), 32'(HUNT));
        checkOutput("badh1_run_len",  run_len, 0);
        sendFrame(4, 2, 1, 4);
        applyStimulus(1'b0);
        checkOutput("relock_match",   matchCount, 4);
        checkOutput("relock_locked",  locked,  1);
        checkOutput("relock_err_cnt", err_cnt, 1);

        $display("[TB] enable gating in R3");
        sendRun(1'b0, 3);
        sendRun(1'b1, 2);
        sendRun(1'b0, 1);
        sendRun(1'b1, 2);
        checkOutput("gate_pre_state", 32'(dut.state_q), 32'(R3));
        checkOutput("gate_pre_run",   run_len, 2);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0);
            checkOutput("gate_run_len", run_len, 2);
            checkOutput("gate_state",   32'(dut.state_q), 32'(R3));
        end
        checkOutput("gate_no_match", matchCount, 4);
        checkOutput("gate_locked",   locked, 1);
        enable = 1'b1;
        sendRun(1'b1, 2);
        applyStimulus(1'b0);
        checkOutput("gate_resume_match", matchCount, 5);
        checkOutput("gate_resume_run",   run_len, 1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1);
        checkOutput("midrst_short_l0_err", err_cnt, 2);
        sendFrame(4, 2, 1, 4);
        applyStimulus(1'b0);
        checkOutput("midrst_relock_match", matchCount, 6);
        sendRun(1'b0, 3);
        sendRun(1'b1, 2);
        sendRun(1'b0, 1);
        sendRun(1'b1, 2);
        checkOutput("midrst_pre_locked", locked,  1);
        checkOutput("midrst_pre_err",    err_cnt, 2);
        checkOutput("midrst_pre_state",  32'(dut.state_q), 32'(R3));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_match",   match,   0);
        checkOutput("midrst_locked",  locked,  0);
        checkOutput("midrst_err_cnt", err_cnt, 0);
        checkOutput("midrst_run_len", run_len, 0);
        checkOutput("midrst_state",   32'(dut.state_q), 32'(HUNT));

        $display("[TB] run-length saturation");
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0);
            if (i == 15) begin
                checkOutput("sat_run_max",    run_len, 15);
                checkOutput("sat_no_err_yet", err_cnt, 0);
            end
            if (i == 16) begin
                checkOutput("sat_err",   err_cnt, 1);
                checkOutput("sat_state", 32'(dut.state_q), 32'(HUNT));
                checkOutput("sat_run",   run_len, 0);
            end
        end
        checkOutput("sat_no_recount", err_cnt, 1);
        checkOutput("sat_hunt_run",   run_len, 0);
        checkOutput("sat_hunt_state", 32'(dut.state_q), 32'(HUNT));

        $display("[TB] error counter saturation");
        applyStimulus(1'b1);
        for (int k = 1; k <= 300; k++) begin
            applyStimulus(1'b0);
            applyStimulus(1'b1);
            if (k == 253) checkOutput("errsat_254", err_cnt, 254);
            if (k == 254) checkOutput("errsat_255", err_cnt, 255);
        end
        checkOutput("errsat_hold",     err_cnt, 255);
        checkOutput("errsat_locked",   locked,  0);
        checkOutput("errsat_no_match", matchCount, 6);
        checkOutput("match_one_cycle", longMatch, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
